// File: rtl/dsram_like_bridge.sv
// dsram_like_bridge: turns the M-stage single-cycle SRAM data port into the
// req / addr_ok / data_ok handshake. It stalls the pipeline while a transaction
// is in flight and issues exactly one bus transaction per memory instruction.
// Optional feature macro: DSRAM_BRIDGE_BYPASS_EN. When defined, load data is
// forwarded straight from the bus in the data_ok cycle, which saves one stall
// cycle.
module dsram_like_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req_valid,
  input  logic              mem_en,
  input  logic [3:0]        mem_wen,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              flush,
  input  logic              other_stall,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_stall,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state, stateNxt;
  logic              cancel;
  logic [ADDR_W-1:0] addrR;
  logic [DATA_W-1:0] wdataR, rdataR;
  logic              wrR;
  logic [1:0]        sizeR;

  logic start, issue, finish, keep, loadDone;

  assign start    = mem_req_valid & mem_en & ~flush;
  assign issue    = (state == IDLE) & start;
  assign finish   = (state == DATA) & data_data_ok;
  // The result is wanted only if no flush has hit this transaction.
  assign keep     = ~cancel & ~flush;
  assign loadDone = finish & keep & ~wrR;

  // Next-state selection for the handshake sequencer.
  always_comb begin
    stateNxt = state;
    case (state)
      IDLE: if (start) stateNxt = data_addr_ok ? DATA : ADDR;
      ADDR: if (data_addr_ok) stateNxt = DATA;
      DATA: begin
        if (data_data_ok) begin
          if (!keep) stateNxt = IDLE;
`ifdef DSRAM_BRIDGE_BYPASS_EN
          else stateNxt = other_stall ? DONE : IDLE;
`else
          else stateNxt = DONE;
`endif
        end
      end
      DONE: if (flush || !other_stall) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // State register and the cancel flag. A cancelled transaction drains to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cancel <= 1'b0;
    end else begin
      state <= stateNxt;
      if (finish) cancel <= 1'b0;
      else if (((state == ADDR) || (state == DATA)) && flush) cancel <= 1'b1;
    end
  end

  // Capture the request fields so they stay stable until addr_ok.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addrR  <= '0;
      wdataR <= '0;
      wrR    <= 1'b0;
      sizeR  <= 2'd0;
    end else if (issue) begin
      addrR  <= mem_addr;
      wdataR <= mem_wdata;
      wrR    <= |mem_wen;
      sizeR  <= mem_size;
    end
  end

  // Latch load data. Store acks and discarded responses leave it untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdataR <= '0;
    else if (loadDone) rdataR <= data_rdata;
  end

  // In the issue cycle the bus fields come straight from the M stage. After
  // that they come from the captured registers.
  always_comb begin
    data_req   = issue | (state == ADDR);
    data_wr    = issue ? (|mem_wen) : wrR;
    data_size  = issue ? mem_size : sizeR;
    data_addr  = issue ? mem_addr : addrR;
    data_wdata = issue ? mem_wdata : wdataR;
  end

  // Stall and load-data return towards the pipeline.
  always_comb begin
    mem_rdata = rdataR;
    if (cancel) mem_stall = mem_req_valid;
    else        mem_stall = issue | (state == ADDR) | (state == DATA);
`ifdef DSRAM_BRIDGE_BYPASS_EN
    if (finish && keep) mem_stall = 1'b0;
    if (loadDone) mem_rdata = data_rdata;
`endif
  end

endmodule

// File: tb/tb_dsram_like_bridge.sv
// Directed bench for dsram_like_bridge. Inputs change 1ns after the rising edge.
// Outputs are sampled on the falling edge.
module tb_dsram_like_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid, mem_en, flush, other_stall;
  logic [3:0]  mem_wen;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_stall, data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;

  int nChecks = 0;
  int nErrors = 0;
  int stallCnt, reqCnt, acceptCnt;

  always #5 clk = ~clk;

  dsram_like_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_en(mem_en), .mem_wen(mem_wen),
    .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .flush(flush), .other_stall(other_stall),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic quiet();
    mem_req_valid = 0; mem_en = 1; flush = 0; other_stall = 0;
    mem_wen = 4'h0; mem_size = 2'd2; mem_addr = 32'h0; mem_wdata = 32'h0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 32'h0;
  endtask

  task automatic load(input logic [31:0] a);
    mem_req_valid = 1; mem_en = 1; mem_wen = 4'h0; mem_size = 2'd2; mem_addr = a;
  endtask

  task automatic nextCycle();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
    if (mem_stall) stallCnt++;
    if (data_req) reqCnt++;
    if (data_req && data_addr_ok) acceptCnt++;
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, "_req"}, {31'h0, data_req}, 32'h0);
    chk({tag, "_wr"}, {31'h0, data_wr}, 32'h0);
    chk({tag, "_size"}, {30'h0, data_size}, 32'h0);
    chk({tag, "_addr"}, data_addr, 32'h0);
    chk({tag, "_wdata"}, data_wdata, 32'h0);
    chk({tag, "_rdata"}, mem_rdata, 32'h0);
    chk({tag, "_stall"}, {31'h0, mem_stall}, 32'h0);
  endtask

  initial begin
    quiet();
    rst = 0;
    #2;
    chkAllZero("rst");
    nextCycle(); nextCycle();
    rst = 1;
    nextCycle();

    // Word load, addr_ok in issue cycle, data_ok next cycle.
    stallCnt = 0; reqCnt = 0; acceptCnt = 0;
    load(32'h1000); data_addr_ok = 1;
    sample();
    chk("ld_req", {31'h0, data_req}, 32'h1);
    chk("ld_wr", {31'h0, data_wr}, 32'h0);
    chk("ld_size", {30'h0, data_size}, 32'h2);
    chk("ld_addr", data_addr, 32'h1000);
    nextCycle();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hDEADBEEF;
    sample();
`ifdef DSRAM_BRIDGE_BYPASS_EN
    chk("ld_bypass_rdata", mem_rdata, 32'hDEADBEEF);
`endif
    nextCycle();
    data_data_ok = 0; data_rdata = 32'h0; mem_req_valid = 0;
    sample();
`ifndef DSRAM_BRIDGE_BYPASS_EN
    chk("ld_done_rdata", mem_rdata, 32'hDEADBEEF);
    chk("ld_stalls", stallCnt, 32'd2);
`else
    chk("ld_stalls", stallCnt, 32'd1);
`endif
    chk("ld_reqcnt", reqCnt, 32'd1);
    nextCycle();

    // Byte store with addr_ok held off for three cycles.
    stallCnt = 0; reqCnt = 0; acceptCnt = 0;
    mem_req_valid = 1; mem_wen = 4'b1000; mem_size = 2'd0;
    mem_addr = 32'h1003; mem_wdata = 32'hAB000000;
    for (int i = 0; i < 4; i++) begin
      data_addr_ok = (i == 3);
      sample();
      chk("st_addr", data_addr, 32'h1003);
      chk("st_wdata", data_wdata, 32'hAB000000);
      chk("st_wr", {31'h0, data_wr}, 32'h1);
      chk("st_size", {30'h0, data_size}, 32'h0);
      nextCycle();
      // Garbage on the M-stage port must not leak onto the bus.
      mem_addr = 32'hFFFF_0000 + i; mem_wdata = 32'h1111_1111 * (i + 1);
    end
    data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'h5555_5555;
    sample();
    chk("st_data_noreq", {31'h0, data_req}, 32'h0);
    nextCycle();
    data_addr_ok = 0; data_data_ok = 0; mem_req_valid = 0;
    sample();
    chk("st_rdata_kept", mem_rdata, 32'hDEADBEEF);
    chk("st_reqcnt", reqCnt, 32'd4);
    chk("st_accepts", acceptCnt, 32'd1);
    nextCycle();

    // Load finishing under another stall source: hold DONE without reissue.
    reqCnt = 0;
    load(32'h2000); data_addr_ok = 1; other_stall = 1;
    sample(); nextCycle();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h12345678;
    sample(); nextCycle();
    data_data_ok = 0; data_rdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("os_stall", {31'h0, mem_stall}, 32'h0);
      chk("os_rdata", mem_rdata, 32'h12345678);
      nextCycle();
    end
    other_stall = 0;
    sample();
    chk("os_reqcnt", reqCnt, 32'd1);
    nextCycle();
    mem_req_valid = 0;
    sample();
    chk("os_idle_req", {31'h0, data_req}, 32'h0);
    nextCycle();

    // Flush during DATA: the response drains, then the next load issues.
    load(32'h2400); data_addr_ok = 1;
    sample(); nextCycle();
    data_addr_ok = 0; flush = 1;
    sample();
    chk("fl_stall_flushcyc", {31'h0, mem_stall}, 32'h1);
    nextCycle();
    flush = 0; load(32'h3000);
    sample();
    chk("fl_track_hi", {31'h0, mem_stall}, 32'h1);
    chk("fl_noreq", {31'h0, data_req}, 32'h0);
    nextCycle();
    mem_req_valid = 0;
    sample();
    chk("fl_track_lo", {31'h0, mem_stall}, 32'h0);
    nextCycle();
    mem_req_valid = 1; data_data_ok = 1; data_rdata = 32'hBAD0BAD0;
    sample();
    chk("fl_drain_stall", {31'h0, mem_stall}, 32'h1);
    chk("fl_drain_noreq", {31'h0, data_req}, 32'h0);
    nextCycle();
    data_data_ok = 0; data_rdata = 32'h0; data_addr_ok = 1;
    sample();
    chk("fl_new_req", {31'h0, data_req}, 32'h1);
    chk("fl_new_addr", data_addr, 32'h3000);
    chk("fl_discard", mem_rdata, 32'h12345678);
    nextCycle();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h0F0F0F0F;
    sample(); nextCycle();
    data_data_ok = 0; mem_req_valid = 0;
    sample();
`ifndef DSRAM_BRIDGE_BYPASS_EN
    chk("fl_new_rdata", mem_rdata, 32'h0F0F0F0F);
`endif
    nextCycle();

    // Address exception and flush in IDLE both suppress the request.
    mem_req_valid = 1; mem_en = 0; mem_addr = 32'h5001;
    sample();
    chk("ae_req", {31'h0, data_req}, 32'h0);
    chk("ae_stall", {31'h0, mem_stall}, 32'h0);
    nextCycle();
    mem_en = 1; flush = 1;
    sample();
    chk("fi_req", {31'h0, data_req}, 32'h0);
    chk("fi_stall", {31'h0, mem_stall}, 32'h0);
    nextCycle();
    quiet();
    nextCycle();

    // Reset while waiting for addr_ok; the late data_ok must be ignored.
    mem_req_valid = 1; mem_wen = 4'hF; mem_addr = 32'h4000; mem_wdata = 32'h55AA55AA;
    sample(); nextCycle();
    sample();
    chk("ra_req_held", {31'h0, data_req}, 32'h1);
    #1;
    mem_req_valid = 0; rst = 0;
    #1;
    chkAllZero("ra");
    nextCycle();
    rst = 1;
    data_data_ok = 1; data_rdata = 32'h99;
    sample();
    chk("ra_late_req", {31'h0, data_req}, 32'h0);
    chk("ra_late_stall", {31'h0, mem_stall}, 32'h0);
    nextCycle();
    data_data_ok = 0;
    sample();
    chk("ra_late_rdata", mem_rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
